// File: rtl/ibr128_round_engine.sv
// IBR128 iterative round engine: one rotate/xor round per clock, 8 or 16 rounds, encrypt or decrypt.
// Define IBR128_ENGINE_ABORT_EN to let block_start = 0 during RUN abandon the block.
module ibr128_round_engine (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         block_start,
    input  logic         encrypt,
    input  logic         sa,
    input  logic [127:0] pData,
    input  logic [63:0]  key0,
    input  logic [63:0]  key1,
    output logic         block_ready,
    output logic [127:0] eData,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    logic [127:0] r_s;
    logic [127:0] r_k;
    logic [127:0] r_edata;
    logic         r_enc;
    logic         r_short;
    logic         r_ready;
    logic [3:0]   r_rnd;

    logic [3:0]   w_last_rnd;
    logic         w_last;
    logic [3:0]   w_key_idx;
    logic [127:0] w_rk;
    logic [127:0] w_round_out;

    function automatic logic [127:0] rotl128(input logic [127:0] x, input logic [6:0] n);
        logic [255:0] dbl;
        dbl = {x, x} << n;
        return dbl[255:128];
    endfunction

    // Decrypt walks the key schedule backwards; rotr by 13 is rotl by 115.
    always_comb begin
        w_last_rnd  = r_short ? 4'd7 : 4'd15;
        w_last      = (r_rnd == w_last_rnd);
        w_key_idx   = r_enc ? r_rnd : (w_last_rnd - r_rnd);
        w_rk        = rotl128(r_k, {w_key_idx, 3'b000});
        w_round_out = r_enc ? rotl128(r_s ^ w_rk, 7'd13)
                            : (rotl128(r_s, 7'd115) ^ w_rk);
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE: if (block_start) w_next_state = RUN;
            RUN: begin
`ifdef IBR128_ENGINE_ABORT_EN
                if (!block_start) w_next_state = IDLE;
                else if (w_last)  w_next_state = DONE;
`else
                if (w_last) w_next_state = DONE;
`endif
            end
            DONE: if (!block_start) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_s     <= '0;
            r_k     <= '0;
            r_edata <= '0;
            r_enc   <= 1'b0;
            r_short <= 1'b0;
            r_ready <= 1'b0;
            r_rnd   <= '0;
        end else begin
            r_ready <= (w_next_state == DONE);
            case (r_state)
                IDLE: begin
                    if (block_start) begin
                        r_s     <= pData;
                        r_k     <= {key0, key1};
                        r_enc   <= encrypt;
                        r_short <= sa;
                        r_rnd   <= '0;
                    end
                end
                RUN: begin
                    r_s   <= w_round_out;
                    r_rnd <= r_rnd + 4'd1;
                    if (w_next_state == DONE) r_edata <= w_round_out;
                end
                default: ;
            endcase
        end
    end

    assign block_ready = r_ready;
    assign eData       = r_edata;
    assign busy        = (r_state == RUN);

endmodule

// File: tb/tb_ibr128_round_engine.sv
// Self-checking bench for ibr128_round_engine: directed vectors plus randomized encrypt/decrypt round trips.
// Abort behaviour expectations follow IBR128_ENGINE_ABORT_EN.
module tb_ibr128_round_engine;

    logic         Clk;
    logic         RstN;
    logic         block_start;
    logic         encrypt;
    logic         sa;
    logic [127:0] pData;
    logic [63:0]  key0;
    logic [63:0]  key1;
    logic         block_ready;
    logic [127:0] eData;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    ibr128_round_engine dut (
        .Clk         (Clk),
        .RstN        (RstN),
        .block_start (block_start),
        .encrypt     (encrypt),
        .sa          (sa),
        .pData       (pData),
        .key0        (key0),
        .key1        (key1),
        .block_ready (block_ready),
        .eData       (eData),
        .busy        (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain loop over the round definition.
    function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
        int m;
        m = n % 128;
        if (m < 0) m += 128;
        if (m == 0) return x;
        return (x << m) | (x >> (128 - m));
    endfunction

    function automatic logic [127:0] ref_block(input bit enc, input bit short_rounds,
                                               input logic [127:0] p, input logic [127:0] k);
        int nr;
        logic [127:0] s;
        nr = short_rounds ? 8 : 16;
        s  = p;
        if (enc) begin
            for (int i = 0; i < nr; i++) s = rotl(s ^ rotl(k, 8 * i), 13);
        end else begin
            for (int i = nr - 1; i >= 0; i--) s = rotl(s, -13) ^ rotl(k, 8 * i);
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic scramble_inputs();
        pData   = rand128();
        key0    = {$urandom, $urandom};
        key1    = {$urandom, $urandom};
        encrypt = 1'($urandom_range(0, 1));
        sa      = 1'($urandom_range(0, 1));
    endtask

    // Counts edges from the start-sampling edge (edge 1) until block_ready.
    task automatic wait_ready(input bit scramble, output int lat);
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (block_ready) begin
                lat = e;
                break;
            end
            check("busy_in_run", 128'(busy), 128'(1));
            if (scramble) scramble_inputs();
        end
        if (lat != 0) check("ready_excl_busy", 128'(busy), 128'(0));
    endtask

    task automatic run_block(input bit enc, input bit short_rounds, input logic [127:0] p,
                             input logic [127:0] k, input bit scramble, output logic [127:0] res);
        int lat;
        @(negedge Clk);
        encrypt     = enc;
        sa          = short_rounds;
        pData       = p;
        {key0, key1} = k;
        block_start = 1'b1;
        wait_ready(scramble, lat);
        check("latency", 128'(lat), short_rounds ? 128'(9) : 128'(17));
        res = eData;
        check("edata_model", eData, ref_block(enc, short_rounds, p, k));
    endtask

    task automatic release_block(input logic [127:0] res);
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            check("hold_ready", 128'(block_ready), 128'(1));
            check("hold_no_restart", 128'(busy), 128'(0));
            check("hold_edata", eData, res);
        end
        block_start = 1'b0;
        @(negedge Clk);
        check("ready_clear", 128'(block_ready), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
        check("edata_retain", eData, res);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] back;
        logic [127:0] p;
        logic [127:0] k;
        bit           s;
        int           lat;
        int           ready_cycles;
        int           first_ready;
        logic         busy_e5;
        logic [127:0] abort_res;

        RstN        = 1'b0;
        block_start = 1'b0;
        encrypt     = 1'b0;
        sa          = 1'b0;
        pData       = '0;
        key0        = '0;
        key1        = '0;
        #12;
        check("rst_ready", 128'(block_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_edata", eData, 128'(0));
        @(negedge Clk);
        RstN = 1'b1;

        run_block(1'b1, 1'b0, 128'd1, 128'd0, 1'b0, res);
        check("vec_k0_16", res, 128'h00000000_00010000_00000000_00000000);
        release_block(res);

        run_block(1'b1, 1'b1, 128'd1, 128'd0, 1'b0, res);
        check("vec_k0_8", res, 128'h00000100_00000000_00000000_00000000);
        release_block(res);

        for (int si = 0; si < 2; si++) begin
            run_block(1'b1, 1'(si), 128'd0, {128{1'b1}}, 1'b0, res);
            check("vec_kones", res, 128'd0);
            release_block(res);
        end

        // Random round trips with inputs scrambled while the block is in flight.
        for (int it = 0; it < 8; it++) begin
            p = rand128();
            k = rand128();
            s = 1'(it % 2);
            run_block(1'b1, s, p, k, 1'b1, res);
            release_block(res);
            run_block(1'b0, s, res, k, 1'b1, back);
            check("roundtrip", back, p);
            release_block(back);
        end

        // Reset pulse in the middle of RUN, block_start held through it.
        p = rand128();
        k = rand128();
        @(negedge Clk);
        encrypt      = 1'b1;
        sa           = 1'b0;
        pData        = p;
        {key0, key1} = k;
        block_start  = 1'b1;
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b0;
        #1;
        check("midrst_ready", 128'(block_ready), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_edata", eData, 128'(0));
        @(negedge Clk);
        RstN = 1'b1;
        wait_ready(1'b0, lat);
        check("restart_latency", 128'(lat), 128'(17));
        check("restart_edata", eData, ref_block(1'b1, 1'b0, p, k));
        res = eData;
        release_block(res);

        // block_start dropped with three rounds done.
        p = rand128();
        k = rand128();
        @(negedge Clk);
        encrypt      = 1'b1;
        sa           = 1'b0;
        pData        = p;
        {key0, key1} = k;
        block_start  = 1'b1;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        block_start  = 1'b0;
        ready_cycles = 0;
        first_ready  = 0;
        busy_e5      = 1'b0;
        abort_res    = '0;
        for (int e = 5; e <= 30; e++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (e == 5) busy_e5 = busy;
            if (block_ready) begin
                ready_cycles++;
                if (first_ready == 0) begin
                    first_ready = e;
                    abort_res   = eData;
                end
            end
        end
`ifdef IBR128_ENGINE_ABORT_EN
        check("abort_ready_cycles", 128'(ready_cycles), 128'(0));
        check("abort_busy", 128'(busy_e5), 128'(0));
`else
        check("drop_ready_cycles", 128'(ready_cycles), 128'(1));
        check("drop_ready_edge", 128'(first_ready), 128'(17));
        check("drop_busy", 128'(busy_e5), 128'(1));
        check("drop_edata", abort_res, ref_block(1'b1, 1'b0, p, k));
`endif
        check("drop_final_busy", 128'(busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ibr128_round_engine.md
IBR128_ROUND_ENGINE -- requirements
Module: ibr128_round_engine

Interface
REQ-001 SHALL use reset RstN, asynchronous, active-low; clock Clk.
REQ-002 SHALL have port Clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port RstN  input  1  asynchronous active-low reset.
REQ-004 SHALL have port block_start  input  1  level request from op-mode initiator; held high until the initiator is disabled.
REQ-005 SHALL have port encrypt  input  1  1 = encrypt rounds, 0 = decrypt rounds; sampled at start.
REQ-006 SHALL have port sa  input  1  short-round select: 1 = 8 rounds, 0 = 16 rounds; sampled at start.
REQ-007 SHALL have port pData  input  128  input block; sampled at start.
REQ-008 SHALL have port key0 / key1  input  64 each  key K = {key0,key1}; sampled at start.
REQ-009 SHALL have port block_ready  output  1  registered result-valid level.
REQ-010 SHALL have port eData  output  128  registered result block, valid while block_ready = 1.
REQ-011 SHALL have port busy  output  1  high in RUN state.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: on an edge with block_start = 1, SHALL latch S = pData, K, encrypt, NR = (sa ? 8 : 16), clear round counter rnd = 0, and go to RUN.
REQ-014 RUN: each edge SHALL apply one round and increment rnd; at the edge applying round NR-1 SHALL go to DONE, load eData = final S and set block_ready = 1.
REQ-015 Latency SHALL be exactly NR+1 edges from the start-sampling edge to block_ready high, i.e. 9 (sa=1) or 17 (sa=0) edges.
REQ-016 Round key SHALL be rk_i = rotl128(K, 8*i) for i = 0..NR-1, rotate amount taken mod 128.
REQ-017 Encrypt round i = rnd SHALL compute S = rotl128(S ^ rk_i, 13).
REQ-018 Decrypt round (rnd = j) SHALL use i = NR-1-j and compute S = rotr128(S, 13) ^ rk_i, exactly inverting REQ-017.
REQ-019 Inputs (pData, key0, key1, encrypt, sa) changing during RUN or DONE SHALL NOT affect the result.
REQ-020 DONE: SHALL hold block_ready = 1 and eData stable while block_start = 1.
REQ-021 DONE: on an edge with block_start = 0, SHALL clear block_ready and go to IDLE; eData SHALL retain its last value.
REQ-022 A new block SHALL be started only from IDLE; block_start continuously high after DONE SHALL NOT start a second block.
REQ-023 busy SHALL be 1 exactly while in RUN; block_ready and busy SHALL never be 1 simultaneously.

Reset
REQ-024 RstN low SHALL immediately force IDLE, block_ready = 0, busy = 0, eData = 0, S = 0, rnd = 0, regardless of state.
REQ-025 After RstN deassertion with block_start already high, the first rising edge SHALL start a block per REQ-013.

Configuration
REQ-026 Macro IBR128_ENGINE_ABORT_EN SHALL control mid-operation abort.
REQ-027 With IBR128_ENGINE_ABORT_EN defined: block_start = 0 sampled in RUN SHALL return the FSM to IDLE at that edge, clear busy, and never assert block_ready for that block.
REQ-028 Without IBR128_ENGINE_ABORT_EN: block_start = 0 in RUN SHALL be ignored; the block completes, enters DONE for one cycle with block_ready = 1, then returns to IDLE per REQ-021.

Verification
REQ-029 K = 0, pData = 1, encrypt = 1, sa = 0, block_start held -> block_ready at edge 17, eData = 0x00000000_00010000_00000000_00000000.
REQ-030 K = 0, pData = 1, encrypt = 1, sa = 1 -> block_ready at edge 9, eData = 0x00000100_00000000_00000000_00000000.
REQ-031 K = all-ones, pData = 0, encrypt = 1, sa = 0 and sa = 1 -> eData = 0 in both cases.
REQ-032 Random K and pData, encrypt then feed eData back with encrypt = 0 and the same sa -> eData equals original pData for both sa values.
REQ-033 RstN pulsed low at RUN round 5 -> block_ready = 0, busy = 0, eData = 0 immediately; block_start high restarts and the block completes with correct latency.
REQ-034 block_start dropped at RUN round 3 -> with macro: IDLE, no block_ready; without macro: block_ready pulses high for exactly one cycle at edge 17.
